// File: rtl/tmrx_err_monitor.sv
// +------------------------------------------------------------------------+
// | tmrx_err_monitor: TMRX error-sink event counter/reporter; optional     |
// | overflow flags via TMRX_ERR_MON_OVF_EN.                    Rev 1.0     |
// +------------------------------------------------------------------------+
`default_nettype none

module tmrx_err_monitor #(
  parameter int NUM_SRC = 4,
  parameter int CNT_W   = 8,
  parameter int SRC_W   = $clog2(NUM_SRC)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [NUM_SRC-1:0] err_i,
  input  logic               clr_i,
  output logic               evt_valid_o,
  input  logic               evt_ready_i,
  output logic [SRC_W-1:0]   evt_src_o,
  output logic [CNT_W-1:0]   evt_cnt_o,
  output logic [NUM_SRC-1:0] sticky_o,
  output logic               irq_o,
  output logic [NUM_SRC-1:0] ovf_o
);

  localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};
  localparam logic [SRC_W:0]   C_NUM_SRC = (SRC_W+1)'(NUM_SRC);
  localparam logic [SRC_W-1:0] C_LAST    = SRC_W'(NUM_SRC - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  state_t               r_state;
  logic [NUM_SRC-1:0]   r_err_q;
  logic [CNT_W-1:0]     r_cnt [NUM_SRC];
  logic [NUM_SRC-1:0]   r_sticky;
  logic [NUM_SRC-1:0]   r_pend;
  logic                 r_irq;
  logic [SRC_W-1:0]     r_rr_ptr;
  logic                 r_evt_valid;
  logic [SRC_W-1:0]     r_evt_src;
  logic [CNT_W-1:0]     r_evt_cnt;

  logic [NUM_SRC-1:0]   w_evt;
  logic                 w_take;
  logic [NUM_SRC-1:0]   w_rot;
  logic [SRC_W:0]       w_off;
  logic [SRC_W:0]       w_sum;
  logic [SRC_W-1:0]     w_sel;
  logic [CNT_W-1:0]     w_cnt_nxt [NUM_SRC];
  logic [NUM_SRC-1:0]   w_sticky_nxt;
  logic [NUM_SRC-1:0]   w_pend_nxt;

  assign w_evt  = err_i & ~r_err_q;
  assign w_take = (r_state == ST_IDLE) && (|r_pend);

  // Rotate pending bits so bit 0 is the round-robin start, then take the lowest set bit.
  always_comb begin
    w_rot = NUM_SRC'({r_pend, r_pend} >> r_rr_ptr);
    w_off = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (w_rot[i]) w_off = (SRC_W+1)'(i);
    end
    w_sum = {1'b0, r_rr_ptr} + w_off;
    if (w_sum >= C_NUM_SRC) w_sum = w_sum - C_NUM_SRC;
    w_sel = w_sum[SRC_W-1:0];
  end

  // Clear is applied first so a coinciding event counts from zero.
  always_comb begin
    w_cnt_nxt    = r_cnt;
    w_sticky_nxt = r_sticky;
    w_pend_nxt   = r_pend;
    if (w_take) w_pend_nxt[w_sel] = 1'b0;
    if (clr_i) begin
      for (int k = 0; k < NUM_SRC; k++) w_cnt_nxt[k] = '0;
      w_sticky_nxt = '0;
      w_pend_nxt   = '0;
    end
    for (int k = 0; k < NUM_SRC; k++) begin
      if (w_evt[k]) begin
        w_sticky_nxt[k] = 1'b1;
        w_pend_nxt[k]   = 1'b1;
        if (w_cnt_nxt[k] != C_CNT_MAX) w_cnt_nxt[k] = w_cnt_nxt[k] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_err_q  <= '0;
      r_sticky <= '0;
      r_pend   <= '0;
      r_irq    <= 1'b0;
      for (int k = 0; k < NUM_SRC; k++) r_cnt[k] <= '0;
    end else begin
      r_err_q  <= err_i;
      r_sticky <= w_sticky_nxt;
      r_pend   <= w_pend_nxt;
      r_irq    <= |r_sticky;
      r_cnt    <= w_cnt_nxt;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= ST_IDLE;
      r_evt_valid <= 1'b0;
      r_evt_src   <= '0;
      r_evt_cnt   <= '0;
      r_rr_ptr    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_take) begin
            r_evt_valid <= 1'b1;
            r_evt_src   <= w_sel;
            r_evt_cnt   <= r_cnt[w_sel];
            r_rr_ptr    <= (w_sel == C_LAST) ? '0 : w_sel + 1'b1;
            r_state     <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (evt_ready_i) begin
            r_evt_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign evt_valid_o = r_evt_valid;
  assign evt_src_o   = r_evt_src;
  assign evt_cnt_o   = r_evt_cnt;
  assign sticky_o    = r_sticky;
  assign irq_o       = r_irq;

`ifdef TMRX_ERR_MON_OVF_EN
  logic [NUM_SRC-1:0] r_ovf;
  logic [NUM_SRC-1:0] w_sat;

  always_comb begin
    w_sat = '0;
    for (int k = 0; k < NUM_SRC; k++) w_sat[k] = (r_cnt[k] == C_CNT_MAX);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)    r_ovf <= '0;
    else if (clr_i) r_ovf <= '0;
    else            r_ovf <= r_ovf | (w_evt & w_sat);
  end

  assign ovf_o = r_ovf;
`else
  assign ovf_o = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_tmrx_err_monitor.sv
// +------------------------------------------------------------------------+
// | tb_tmrx_err_monitor: scoreboard bench with event-level reference model |
// |                                                            Rev 1.0     |
// +------------------------------------------------------------------------+
`default_nettype none

module tb_tmrx_err_monitor;

  localparam int N   = 4;
  localparam int CW  = 3;
  localparam int SW  = 2;
  localparam int MAX = (1 << CW) - 1;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic [N-1:0]  err_i = '0;
  logic          clr_i = 1'b0;
  logic          evt_ready_i = 1'b0;
  logic          evt_valid_o;
  logic [SW-1:0] evt_src_o;
  logic [CW-1:0] evt_cnt_o;
  logic [N-1:0]  sticky_o;
  logic          irq_o;
  logic [N-1:0]  ovf_o;

  always #5 clk_i = ~clk_i;

  tmrx_err_monitor #(.NUM_SRC(N), .CNT_W(CW)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .err_i       (err_i),
    .clr_i       (clr_i),
    .evt_valid_o (evt_valid_o),
    .evt_ready_i (evt_ready_i),
    .evt_src_o   (evt_src_o),
    .evt_cnt_o   (evt_cnt_o),
    .sticky_o    (sticky_o),
    .irq_o       (irq_o),
    .ovf_o       (ovf_o)
  );

  int n_cmp = 0;
  int n_err = 0;
  bit running = 0;

  int           m_cnt [N];
  logic [N-1:0] m_sticky, m_pend, m_ovf, m_prev;
  logic         m_irq, m_busy;
  int           m_last;
  int           q_src[$];
  int           q_cnt[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < N; k++) m_cnt[k] = 0;
    m_sticky = '0; m_pend = '0; m_ovf = '0; m_prev = '0;
    m_irq = 1'b0; m_busy = 1'b0; m_last = N - 1;
    q_src.delete(); q_cnt.delete();
  endtask

  // One clock edge of the specified behaviour, evaluated on the pre-edge inputs.
  task automatic model_step();
    logic [N-1:0] ev;
    ev = err_i & ~m_prev;
    m_irq = |m_sticky;
    if (m_busy) begin
      if (evt_ready_i) m_busy = 1'b0;
    end else if (m_pend != '0) begin
      for (int i = 1; i <= N; i++) begin
        int s;
        s = (m_last + i) % N;
        if (m_pend[s]) begin
          q_src.push_back(s);
          q_cnt.push_back(m_cnt[s]);
          m_pend[s] = 1'b0;
          m_busy = 1'b1;
          m_last = s;
          break;
        end
      end
    end
    if (clr_i) begin
      for (int k = 0; k < N; k++) m_cnt[k] = 0;
      m_sticky = '0; m_pend = '0; m_ovf = '0;
    end
    for (int k = 0; k < N; k++) begin
      if (ev[k]) begin
`ifdef TMRX_ERR_MON_OVF_EN
        if (m_cnt[k] == MAX) m_ovf[k] = 1'b1;
`endif
        if (m_cnt[k] < MAX) m_cnt[k] = m_cnt[k] + 1;
        m_sticky[k] = 1'b1;
        m_pend[k] = 1'b1;
      end
    end
    m_prev = err_i;
  endtask

  task automatic cyc();
    @(posedge clk_i);
    if (rst_ni) model_step();
    #2;
  endtask

  always @(negedge clk_i) begin
    if (rst_ni && running) begin
      chk("valid", 32'(evt_valid_o), 32'(m_busy));
      chk("sticky", 32'(sticky_o), 32'(m_sticky));
      chk("irq", 32'(irq_o), 32'(m_irq));
      chk("ovf", 32'(ovf_o), 32'(m_ovf));
      if (evt_valid_o) begin
        if (q_src.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_report: got src %0d cnt %0d expected none", evt_src_o, evt_cnt_o);
        end else begin
          chk("evt_src", 32'(evt_src_o), 32'(q_src[0]));
          chk("evt_cnt", 32'(evt_cnt_o), 32'(q_cnt[0]));
          if (evt_ready_i) begin
            void'(q_src.pop_front());
            void'(q_cnt.pop_front());
          end
        end
      end
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"},  32'(evt_valid_o), 32'd0);
    chk({tag, "_src"},    32'(evt_src_o),   32'd0);
    chk({tag, "_cnt"},    32'(evt_cnt_o),   32'd0);
    chk({tag, "_sticky"}, 32'(sticky_o),    32'd0);
    chk({tag, "_irq"},    32'(irq_o),       32'd0);
    chk({tag, "_ovf"},    32'(ovf_o),       32'd0);
  endtask

  initial begin
    model_reset();
    repeat (3) cyc();
    chk_all_zero("reset");
    rst_ni = 1'b1;
    running = 1;

    // single event on src 2
    evt_ready_i = 1'b1;
    err_i = 4'b0100; cyc(); err_i = '0;
    repeat (6) cyc();

    // round-robin across simultaneous rises
    err_i = 4'b1011; cyc(); err_i = '0;
    repeat (10) cyc();

    // backpressure with coalescing on src 1
    clr_i = 1'b1; cyc(); clr_i = 1'b0;
    evt_ready_i = 1'b0;
    err_i = 4'b0010; cyc(); err_i = '0;
    repeat (3) cyc();
    repeat (3) begin
      err_i = 4'b0010; cyc(); err_i = '0; cyc();
    end
    repeat (3) cyc();
    evt_ready_i = 1'b1;
    repeat (8) cyc();

    // clear coinciding with a rise on src 0
    clr_i = 1'b1; err_i = 4'b0001; cyc(); clr_i = 1'b0; err_i = '0;
    repeat (6) cyc();

    // saturation on src 3
    clr_i = 1'b1; cyc(); clr_i = 1'b0;
    repeat (MAX + 2) begin
      err_i = 4'b1000; cyc(); err_i = '0; cyc();
    end
    repeat (6) cyc();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      err_i = N'($urandom & $urandom);
      evt_ready_i = ($urandom_range(0, 3) != 0);
      clr_i = ($urandom_range(0, 47) == 0);
      cyc();
    end
    err_i = '0; clr_i = 1'b0; evt_ready_i = 1'b1;
    repeat (20) cyc();
    chk("drain_queue", 32'(q_src.size()), 32'd0);

    // reset while a report is held
    evt_ready_i = 1'b0;
    err_i = 4'b0001; cyc(); err_i = '0;
    for (int i = 0; i < 10 && !evt_valid_o; i++) cyc();
    chk("rst_wait_valid", 32'(evt_valid_o), 32'd1);
    rst_ni = 1'b0;
    running = 0;
    #1;
    chk_all_zero("midsend_rst");
    model_reset();
    repeat (2) cyc();
    rst_ni = 1'b1;
    running = 1;
    evt_ready_i = 1'b1;
    repeat (10) cyc();
    chk("post_rst_queue", 32'(q_src.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/tmrx_err_monitor.md
# tmrx_err_monitor

Error-sink consumer for TMRX-hardened designs. It collects the per-domain error flags that triplicated voters drive onto `tmrx_error_sink` ports. For each flag it detects new error events, keeps a saturating per-source count and a sticky flag, and reports events one at a time over a valid/ready channel. It sits at the top level, where all error sinks converge, and feeds a status register block or a debug host.

## Interface
- `NUM_SRC`, 4: number of error sources, ≥2.
- `CNT_W`, 8: width of each per-source event counter, ≥2.
- `SRC_W`, `$clog2(NUM_SRC)`: derived width of the source index.

Ports:
- `clk_i`  in  1  clock; all logic on the rising edge.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `err_i`  in  NUM_SRC  error flags, synchronous to `clk_i`, level-high.
- `clr_i`  in  1  single-cycle clear of counters, sticky flags and pending flags.
- `evt_valid_o`  out  1  event report valid.
- `evt_ready_i`  in  1  consumer accepts the event.
- `evt_src_o`  out  SRC_W  index of the reported source.
- `evt_cnt_o`  out  CNT_W  counter value of that source at selection.
- `sticky_o`  out  NUM_SRC  per-source "error ever seen since clear".
- `irq_o`  out  1  OR of `sticky_o`, registered.
- `ovf_o`  out  NUM_SRC  counter-overflow flags (see Configuration).

## Operation
- **Edge detect.** `err_q` registers `err_i`. An event on source k is `err_i[k] & ~err_q[k]`. A flag held high counts once.
- **Per event on source k:**
  - `cnt[k]` increments, saturating at 2^CNT_W−1.
  - `sticky[k]` is set.
  - `pend[k]` is set.
- **Coalescing.** Further events on a source whose `pend` is already set increment the counter but do not queue a second report.
- **Report FSM, IDLE:**
  - If any `pend` bit is set, select source s by round-robin, starting from the index after the last reported source (index 0 after reset).
  - Latch s into `evt_src_o` and `cnt[s]` into `evt_cnt_o`, clear `pend[s]`, assert `evt_valid_o`, go to SEND.
- **Report FSM, SEND:**
  - Hold `evt_valid_o`, `evt_src_o` and `evt_cnt_o` stable until `evt_valid_o & evt_ready_i`.
  - On that handshake, deassert `evt_valid_o` and return to IDLE.
  - The minimum gap between reports is one idle cycle.
- **Event during SEND on the in-flight source.** This is a new event, so it sets `pend[s]` again. It is reported later with the updated count.
- **clr_i:**
  - Zeroes all `cnt`, `sticky`, `pend` and `ovf` on the next edge.
  - An in-flight SEND is unaffected and completes normally.
  - If an event on source k coincides with `clr_i`, the event wins: `cnt[k]=1`, `sticky[k]=1`, `pend[k]=1`.
- **`irq_o`.** Registered `|sticky`; it lags `sticky_o` by one cycle.

## Timing
- **Reset values.** All outputs and internal state are 0: `evt_valid_o=0`, `evt_src_o=0`, `evt_cnt_o=0`, `sticky_o=0`, `irq_o=0`, `ovf_o=0`. FSM is in IDLE and `err_q=0`.
- **Flag high during or at exit of reset.** Because `err_q=0`, a flag high at the first edge after reset release counts as an event.
- **Event to outputs.**
  - `err_i` rises before edge t: `cnt`, `sticky_o` and `pend` update at edge t.
  - `evt_valid_o` is asserted at t+1, if the FSM is idle.
  - `irq_o` is asserted at t+1.
- **Back-to-back reports.** With ready held high, one report completes every 2 cycles.
- **Reset mid-SEND.** The report is dropped and all state returns to reset values.
- **Saturation.** At 2^CNT_W−1, further events leave the counter unchanged but still set `pend`.

## Configuration
- **`TMRX_ERR_MON_OVF_EN` defined:**
  - `ovf[k]` is set when an event arrives while `cnt[k]` is saturated.
  - It is sticky until `clr_i` or reset, and drives `ovf_o`.
- **`TMRX_ERR_MON_OVF_EN` undefined:**
  - The overflow logic is absent and `ovf_o` is tied to 0.
  - The port remains, so the interface does not change.

## Test plan
- **Single event.** Reset, then pulse `err_i[2]` for 1 cycle with `evt_ready_i=1`:
  - `evt_valid_o` high exactly 2 cycles after the rise, with `evt_src_o=2`, `evt_cnt_o=1`.
  - `sticky_o=4'b0100` and `irq_o=1`.
- **Round-robin.** Raise `err_i=4'b1011` in one cycle with ready=1: reports arrive in order src 0, 1, 3, each with cnt=1, 2 cycles apart.
- **Backpressure and coalescing.**
  - Hold ready=0 after a src 1 report is presented, then pulse `err_i[1]` 3 more times.
  - Outputs stay stable while ready=0.
  - On release, the next report is src 1 with cnt=4.
- **Clear collision.** Assert `clr_i` in the same cycle as an `err_i[0]` rise: `cnt[0]=1`, `sticky_o=4'b0001`, all other counters 0.
- **Saturation, CNT_W=2.**
  - 5 events on src 3: the last report has cnt=3.
  - With the macro defined, `ovf_o[3]=1`; without it, `ovf_o[3]=0`.
- **Reset mid-SEND.** Drop `rst_ni` while `evt_valid_o=1`, ready=0: all outputs are 0 immediately, and no report appears after release.
